// File: rtl/lcd_frame_monitor.sv
// lcd_frame_monitor: samples the LCD HD/VD/DEN/RGB stream once per pixel
// strobe, measures line and frame geometry, accumulates a per-frame RGB
// checksum and publishes a compact per-frame verdict on every VD fall.
module lcd_frame_monitor #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned H_TOTAL  = 1056
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        pix_en_i,
   input  logic        hd_i,
   input  logic        vd_i,
   input  logic        den_i,
   input  logic [7:0]  r_i,
   input  logic [7:0]  g_i,
   input  logic [7:0]  b_i,
   output logic        frame_done_o,
   output logic        frame_ok_o,
   output logic [9:0]  lines_o,
   output logic [10:0] last_line_pix_o,
   output logic [23:0] checksum_o,
   output logic [7:0]  err_cnt_o
);

   localparam int unsigned PIX_W  = 11;
   localparam int unsigned LINE_W = 10;
   localparam int unsigned CSUM_W = 24;
   localparam int unsigned ERR_W  = 8;

   localparam logic [PIX_W-1:0]  PIX_MAX    = {PIX_W{1'b1}};
   localparam logic [LINE_W-1:0] LINE_MAX   = {LINE_W{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};
   localparam logic [PIX_W-1:0]  H_ACTIVE_C = PIX_W'(H_ACTIVE);
   localparam logic [PIX_W-1:0]  H_TOTAL_C  = PIX_W'(H_TOTAL);
   localparam logic [LINE_W-1:0] V_ACTIVE_C = LINE_W'(V_ACTIVE);

   typedef enum logic {
      WAIT_VD  = 1'b0,
      IN_FRAME = 1'b1
   } state_e;

   state_e             state_q, state_d;

   // previous-sample registers for edge detection
   logic               hd_prev_q, hd_prev_d;
   logic               vd_prev_q, vd_prev_d;
   logic               den_prev_q, den_prev_d;

   // per-frame working state
   logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
   logic [PIX_W-1:0]   hcnt_q, hcnt_d;
   logic               hd_seen_q, hd_seen_d;
   logic               line_err_q, line_err_d;
   logic [CSUM_W-1:0]  csum_q, csum_d;

   // reported values
   logic               frame_done_q, frame_done_d;
   logic               frame_ok_q, frame_ok_d;
   logic [LINE_W-1:0]  lines_q, lines_d;
   logic [PIX_W-1:0]   last_line_pix_q, last_line_pix_d;
   logic [CSUM_W-1:0]  checksum_q, checksum_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

   logic               hd_fall_c;
   logic               vd_fall_c;
   logic               den_fall_c;
   logic               frame_good_c;

   assign hd_fall_c  = hd_prev_q  & ~hd_i;
   assign vd_fall_c  = vd_prev_q  & ~vd_i;
   assign den_fall_c = den_prev_q & ~den_i;

   // next-state: line/frame accounting, evaluated only on pixel strobes
   always_comb begin
      state_d         = state_q;
      hd_prev_d       = hd_prev_q;
      vd_prev_d       = vd_prev_q;
      den_prev_d      = den_prev_q;
      pix_cnt_d       = pix_cnt_q;
      line_cnt_d      = line_cnt_q;
      hcnt_d          = hcnt_q;
      hd_seen_d       = hd_seen_q;
      line_err_d      = line_err_q;
      csum_d          = csum_q;
      frame_done_d    = 1'b0;
      frame_ok_d      = frame_ok_q;
      lines_d         = lines_q;
      last_line_pix_d = last_line_pix_q;
      checksum_d      = checksum_q;
      err_cnt_d       = err_cnt_q;
      frame_good_c    = 1'b0;

      if (pix_en_i) begin
         hd_prev_d  = hd_i;
         vd_prev_d  = vd_i;
         den_prev_d = den_i;

         case (state_q)
            WAIT_VD: begin
               if (vd_fall_c) begin
                  pix_cnt_d  = '0;
                  line_cnt_d = '0;
                  hcnt_d     = '0;
                  hd_seen_d  = 1'b0;
                  line_err_d = 1'b0;
                  csum_d     = '0;
                  state_d    = IN_FRAME;
               end
            end

            IN_FRAME: begin
               // active pixel: count it and fold it into the checksum
               if (den_i) begin
                  if (pix_cnt_q != PIX_MAX) begin
                     pix_cnt_d = pix_cnt_q + PIX_W'(1);
                  end
                  csum_d = csum_q + {r_i, g_i, b_i};
               end

               // DEN fall closes the current line
               if (den_fall_c) begin
                  last_line_pix_d = pix_cnt_q;
                  if (pix_cnt_q != H_ACTIVE_C) begin
                     line_err_d = 1'b1;
                  end
                  if (line_cnt_q != LINE_MAX) begin
                     line_cnt_d = line_cnt_q + LINE_W'(1);
                  end
                  pix_cnt_d = '0;
               end

               // HD period check; the first HD fall of a frame only arms it
               if (hd_fall_c) begin
                  if (hd_seen_q && (hcnt_q != H_TOTAL_C)) begin
                     line_err_d = 1'b1;
                  end
                  hcnt_d    = PIX_W'(1);
                  hd_seen_d = 1'b1;
               end else if (hcnt_q != PIX_MAX) begin
                  hcnt_d = hcnt_q + PIX_W'(1);
               end

               // VD fall publishes the report including this strobe's events
               if (vd_fall_c) begin
                  frame_good_c = (line_cnt_d == V_ACTIVE_C) && !line_err_d;
                  lines_d      = line_cnt_d;
                  checksum_d   = csum_d;
                  frame_ok_d   = frame_good_c;
                  frame_done_d = 1'b1;
                  if (!frame_good_c && (err_cnt_q != ERR_MAX)) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
                  pix_cnt_d  = '0;
                  line_cnt_d = '0;
                  hcnt_d     = '0;
                  hd_seen_d  = 1'b0;
                  line_err_d = 1'b0;
                  csum_d     = '0;
               end
            end

            default: state_d = WAIT_VD;
         endcase
      end
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= WAIT_VD;
         hd_prev_q       <= 1'b1;
         vd_prev_q       <= 1'b1;
         den_prev_q      <= 1'b0;
         pix_cnt_q       <= '0;
         line_cnt_q      <= '0;
         hcnt_q          <= '0;
         hd_seen_q       <= 1'b0;
         line_err_q      <= 1'b0;
         csum_q          <= '0;
         frame_done_q    <= 1'b0;
         frame_ok_q      <= 1'b0;
         lines_q         <= '0;
         last_line_pix_q <= '0;
         checksum_q      <= '0;
         err_cnt_q       <= '0;
      end else begin
         state_q         <= state_d;
         hd_prev_q       <= hd_prev_d;
         vd_prev_q       <= vd_prev_d;
         den_prev_q      <= den_prev_d;
         pix_cnt_q       <= pix_cnt_d;
         line_cnt_q      <= line_cnt_d;
         hcnt_q          <= hcnt_d;
         hd_seen_q       <= hd_seen_d;
         line_err_q      <= line_err_d;
         csum_q          <= csum_d;
         frame_done_q    <= frame_done_d;
         frame_ok_q      <= frame_ok_d;
         lines_q         <= lines_d;
         last_line_pix_q <= last_line_pix_d;
         checksum_q      <= checksum_d;
         err_cnt_q       <= err_cnt_d;
      end
   end

   assign frame_done_o    = frame_done_q;
   assign frame_ok_o      = frame_ok_q;
   assign lines_o         = lines_q;
   assign last_line_pix_o = last_line_pix_q;
   assign checksum_o      = checksum_q;
   assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_lcd_frame_monitor.sv
// tb_lcd_frame_monitor: directed frames on a scaled-down geometry
// (8 active pixels, 4 active lines, 12 strobes per line).
module tb_lcd_frame_monitor;

   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HT = 12;
   localparam logic [23:0] JUNK = 24'hA5A5A5;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        pix_en_i;
   logic        hd_i, vd_i, den_i;
   logic [7:0]  r_i, g_i, b_i;
   logic        frame_done_o;
   logic        frame_ok_o;
   logic [9:0]  lines_o;
   logic [10:0] last_line_pix_o;
   logic [23:0] checksum_o;
   logic [7:0]  err_cnt_o;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [23:0] rgb;
      int          n_lines;
      int          odd_line;
      int          odd_npix;
      int          short_hd_line;
      int          coincide;
      int          gap_line;
      logic [9:0]  exp_lines;
      logic [23:0] exp_csum;
      logic        exp_ok;
      logic [7:0]  exp_err;
      logic [10:0] exp_llp;
   } vec_t;

   vec_t vecs [9];

   lcd_frame_monitor #(
      .H_ACTIVE(HA),
      .V_ACTIVE(VA),
      .H_TOTAL (HT)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .pix_en_i       (pix_en_i),
      .hd_i           (hd_i),
      .vd_i           (vd_i),
      .den_i          (den_i),
      .r_i            (r_i),
      .g_i            (g_i),
      .b_i            (b_i),
      .frame_done_o   (frame_done_o),
      .frame_ok_o     (frame_ok_o),
      .lines_o        (lines_o),
      .last_line_pix_o(last_line_pix_o),
      .checksum_o     (checksum_o),
      .err_cnt_o      (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_done"},  32'(frame_done_o),    32'd0);
      check({tag, "_ok"},    32'(frame_ok_o),      32'd0);
      check({tag, "_lines"}, 32'(lines_o),         32'd0);
      check({tag, "_llp"},   32'(last_line_pix_o), 32'd0);
      check({tag, "_csum"},  32'(checksum_o),      32'd0);
      check({tag, "_err"},   32'(err_cnt_o),       32'd0);
   endtask

   // one pixel strobe; outputs are inspected 1 time unit after the edge
   task automatic strobe(input logic hd, input logic vd, input logic den, input logic [23:0] rgb);
      pix_en_i = 1'b1;
      hd_i     = hd;
      vd_i     = vd;
      den_i    = den;
      {r_i, g_i, b_i} = rgb;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_gap(input int n);
      pix_en_i = 1'b0;
      repeat (n) begin
         hd_i  = 1'($urandom);
         vd_i  = 1'($urandom);
         den_i = 1'($urandom);
         {r_i, g_i, b_i} = 24'($urandom);
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic send_line(input int npix, input int len, input int shift,
                            input logic [23:0] rgb, input int gap_at);
      logic den;
      for (int s = 0; s < len; s++) begin
         if (s == gap_at) idle_gap(100);
         den = (s >= 3 + shift) && (s < 3 + shift + npix);
         strobe((s < 2) ? 1'b0 : 1'b1, 1'b1, den, den ? rgb : JUNK);
      end
   endtask

   task automatic send_body(input vec_t v);
      for (int l = 0; l < v.n_lines; l++) begin
         send_line((l == v.odd_line) ? v.odd_npix : HA,
                   (l == v.short_hd_line) ? HT - 1 : HT,
                   (v.coincide != 0 && l == v.n_lines - 1) ? 1 : 0,
                   v.rgb,
                   (l == v.gap_line) ? 6 : -1);
      end
   endtask

   // VD fall strobe, also an HD fall, DEN low
   task automatic vd_strobe();
      strobe(1'b0, 1'b0, 1'b0, JUNK);
   endtask

   // rest of the vertical sync line; FRAME_DONE must already be gone
   task automatic finish_sync();
      strobe(1'b0, 1'b0, 1'b0, JUNK);
      check("done_width", 32'(frame_done_o), 32'd0);
      for (int s = 2; s < HT; s++) strobe(1'b1, 1'b1, 1'b0, JUNK);
   endtask

   initial begin
      //          rgb          nl odd npx shd coin gap  lines csum         ok err llp
      vecs[0] = '{24'h000001,  4, -1, 8,  -1, 0,  -1,  10'd4, 24'h000020, 1'b1, 8'd0, 11'd8};
      vecs[1] = '{24'h000001,  4,  1, 7,  -1, 0,  -1,  10'd4, 24'h00001F, 1'b0, 8'd1, 11'd8};
      vecs[2] = '{24'h000001,  4, -1, 8,   2, 0,  -1,  10'd4, 24'h000020, 1'b0, 8'd2, 11'd8};
      vecs[3] = '{24'h000002,  4, -1, 8,  -1, 1,  -1,  10'd4, 24'h000040, 1'b1, 8'd2, 11'd8};
      vecs[4] = '{24'h000001,  4, -1, 8,  -1, 0,   2,  10'd4, 24'h000020, 1'b1, 8'd2, 11'd8};
      vecs[5] = '{24'hFFFFFF,  4, -1, 8,  -1, 0,  -1,  10'd4, 24'hFFFFE0, 1'b1, 8'd2, 11'd8};
      vecs[6] = '{24'h000001,  5, -1, 8,  -1, 0,  -1,  10'd5, 24'h000028, 1'b0, 8'd3, 11'd8};
      vecs[7] = '{24'h000001,  3, -1, 8,  -1, 0,  -1,  10'd3, 24'h000018, 1'b0, 8'd4, 11'd8};
      vecs[8] = '{24'h000001,  4,  3, 9,  -1, 0,  -1,  10'd4, 24'h000021, 1'b0, 8'd5, 11'd9};

      rst_i    = 1'b1;
      pix_en_i = 1'b0;
      hd_i     = 1'b1;
      vd_i     = 1'b1;
      den_i    = 1'b0;
      {r_i, g_i, b_i} = 24'h0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check_all_zero("reset");

      // lines before any VD fall are ignored
      send_line(HA, HT, 0, 24'h000001, -1);
      send_line(HA, HT, 0, 24'h000001, -1);
      check("wait_vd_llp", 32'(last_line_pix_o), 32'd0);

      vd_strobe();
      check("first_vd_no_done", 32'(frame_done_o), 32'd0);
      finish_sync();

      for (int i = 0; i < 9; i++) begin
         send_body(vecs[i]);
         vd_strobe();
         check($sformatf("v%0d_done", i),  32'(frame_done_o),    32'd1);
         check($sformatf("v%0d_lines", i), 32'(lines_o),         32'(vecs[i].exp_lines));
         check($sformatf("v%0d_csum", i),  32'(checksum_o),      32'(vecs[i].exp_csum));
         check($sformatf("v%0d_ok", i),    32'(frame_ok_o),      32'(vecs[i].exp_ok));
         check($sformatf("v%0d_err", i),   32'(err_cnt_o),       32'(vecs[i].exp_err));
         check($sformatf("v%0d_llp", i),   32'(last_line_pix_o), 32'(vecs[i].exp_llp));
         finish_sync();
      end

      // empty frames drive the error counter into saturation
      repeat (252) begin
         vd_strobe();
         finish_sync();
      end
      check("sat_err",   32'(err_cnt_o),  32'd255);
      check("sat_lines", 32'(lines_o),    32'd0);
      check("sat_ok",    32'(frame_ok_o), 32'd0);
      check("sat_csum",  32'(checksum_o), 32'd0);

      // one-cycle reset in the middle of a frame
      send_line(HA, HT, 0, 24'h000001, -1);
      send_line(HA, HT, 0, 24'h000001, -1);
      rst_i    = 1'b1;
      pix_en_i = 1'b1;
      hd_i     = 1'b1;
      vd_i     = 1'b1;
      den_i    = 1'b1;
      {r_i, g_i, b_i} = 24'h000001;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check_all_zero("midrst");
      send_line(HA, HT, 0, 24'h000001, -1);
      send_line(HA, HT, 0, 24'h000001, -1);
      vd_strobe();
      check("midrst_vd_no_done", 32'(frame_done_o), 32'd0);
      check("midrst_vd_lines",   32'(lines_o),      32'd0);
      finish_sync();
      send_body(vecs[0]);
      vd_strobe();
      check("post_rst_done",  32'(frame_done_o),    32'd1);
      check("post_rst_lines", 32'(lines_o),         32'd4);
      check("post_rst_csum",  32'(checksum_o),      32'h000020);
      check("post_rst_ok",    32'(frame_ok_o),      32'd1);
      check("post_rst_err",   32'(err_cnt_o),       32'd0);
      check("post_rst_llp",   32'(last_line_pix_o), 32'd8);
      finish_sync();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
